// File: rtl/sar_converter_if.sv
// sar_converter_if: the soc/eoc conversion handshake, plus the DAC code and
// comparator bit exchanged with the analog front end.
// The master side is the consumer/analog environment. The slave side is the
// converter.
interface sar_converter_if #(
    parameter int N = 8
);
    logic         soc;
    logic         eoc;
    logic [N-1:0] x;
    logic [N-1:0] dac;
    logic         cmp;

    modport master (
        output soc,
        output cmp,
        input  eoc,
        input  x,
        input  dac
    );

    modport slave (
        input  soc,
        input  cmp,
        output eoc,
        output x,
        output dac
    );
endinterface

// File: rtl/sar_converter.sv
// sar_converter: N-bit successive-approximation converter. It sits on the
// responder side of the four-phase soc/eoc handshake.
// Each bit window lasts SETTLE+1 cycles. The comparator is read on the last
// edge of the window, when cnt is 0.
// Optional build macro SAR_CMP_MAJORITY_EN makes each bit decision a 2-of-3
// majority. The three comparator samples are taken on the cnt==2, 1 and 0
// edges of the window. This needs SETTLE >= 2.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | eoc=1, x/dac hold; soc=1 starts a conversion
//   S_CONV | eoc=0, settling/deciding bit i; soc ignored
//   S_DONE | eoc=0, result in x; waits for soc=0 before raising eoc
module sar_converter #(
    parameter int N      = 8,
    parameter int SETTLE = 2
) (
    input  logic            clock,
    input  logic            reset_,
    sar_converter_if.slave  bus
);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] I_TOP    = IW'(N - 1);
    localparam logic [IW-1:0] I_ONE    = IW'(1);
    localparam logic [N-1:0]  DAC_MSB  = N'(1) << (N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          eoc_q, eoc_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  dac_q, dac_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] i_dn;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decision;

    assign i_dn = i_q - I_ONE;

`ifdef SAR_CMP_MAJORITY_EN
    if (SETTLE < 2) begin : g_settle_check
        $error("sar_converter: SAR_CMP_MAJORITY_EN requires SETTLE >= 2");
    end

    logic smp_hi_q;
    logic smp_mid_q;

    // Capture the comparator on the cnt==2 and cnt==1 edges of each bit window
    always_ff @(posedge clock) begin
        if (!reset_) begin
            smp_hi_q  <= 1'b0;
            smp_mid_q <= 1'b0;
        end else if (state_q == S_CONV) begin
            if (cnt_q == CW'(2)) smp_hi_q  <= bus.cmp;
            if (cnt_q == CNT_ONE) smp_mid_q <= bus.cmp;
        end
    end

    // 2-of-3 vote with the live sample taken on the decision edge
    always_comb begin
        decision = (smp_hi_q & smp_mid_q) | (smp_hi_q & bus.cmp) | (smp_mid_q & bus.cmp);
    end
`else
    // Single sample on the decision edge; earlier samples in the window are ignored
    always_comb begin
        decision = bus.cmp;
    end
`endif

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            eoc_q   <= 1'b1;
            x_q     <= '0;
            dac_q   <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
            x_q     <= x_d;
            dac_q   <= dac_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state says otherwise
    always_comb begin
        state_d = state_q;
        eoc_d   = eoc_q;
        x_d     = x_q;
        dac_d   = dac_q;
        i_d     = i_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                eoc_d = 1'b1;
                if (bus.soc) begin
                    eoc_d   = 1'b0;
                    dac_d   = DAC_MSB;
                    i_d     = I_TOP;
                    cnt_d   = CNT_LOAD;
                    state_d = S_CONV;
                end
            end

            S_CONV: begin
                eoc_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Pure set/clear on the trial bit: no carries in the search
                    dac_d[i_q] = decision;
                    if (i_q != '0) begin
                        dac_d[i_dn] = 1'b1;
                        i_d         = i_dn;
                        cnt_d       = CNT_LOAD;
                    end else begin
                        x_d     = dac_d;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                eoc_d = 1'b0;
                if (!bus.soc) begin
                    eoc_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                eoc_d   = 1'b1;
            end
        endcase
    end

    assign bus.eoc = eoc_q;
    assign bus.x   = x_q;
    assign bus.dac = dac_q;
endmodule

// File: tb/tb_sar_converter.sv
// tb_sar_converter: directed checks of sar_converter with N=8, SETTLE=2.
// The comparator is modelled as (V >= dac), with an optional one-cycle inversion.
module tb_sar_converter;
    logic clock;
    logic reset_;
    logic [7:0] v_in;
    logic glitch;

    int n_checks;
    int n_errors;

    sar_converter_if #(.N(8)) bus ();

    sar_converter #(.N(8), .SETTLE(2)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    assign bus.cmp = (v_in >= bus.dac) ^ glitch;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One conversion. The edge on which soc is first seen is edge k (e=0).
    // soc is dropped after edge soc_hold. The comparator is inverted for edge
    // glitch_edge only. check_seq walks the DAC sequence for V=0xA7.
    task automatic do_conv(input string tag, input logic [7:0] v, input logic [7:0] exp_x,
                           input logic [7:0] old_x, input int soc_hold, input int glitch_edge,
                           input bit check_seq);
        logic [7:0] seq [0:7];
        int rise;
        seq[0] = 8'h80; seq[1] = 8'hC0; seq[2] = 8'hA0; seq[3] = 8'hB0;
        seq[4] = 8'hA8; seq[5] = 8'hA4; seq[6] = 8'hA6; seq[7] = 8'hA7;
        rise = (soc_hold >= 24) ? soc_hold + 1 : 25;
        v_in = v;
        bus.soc = 1'b1;
        tick();
        chk({tag, "_eoc_drop"}, 32'(bus.eoc), 32'd0);
        chk({tag, "_dac_first"}, 32'(bus.dac), 32'h80);
        for (int e = 1; e <= rise; e++) begin
            if (e == glitch_edge) glitch = 1'b1;
            tick();
            glitch = 1'b0;
            if (e == soc_hold) bus.soc = 1'b0;
            if (check_seq && (e % 3 == 0) && (e <= 21))
                chk($sformatf("%s_dac_seq%0d", tag, e / 3), 32'(bus.dac), 32'(seq[e / 3]));
            if (e == 23) begin
                chk({tag, "_x_old_held"}, 32'(bus.x), 32'(old_x));
                chk({tag, "_eoc_busy"}, 32'(bus.eoc), 32'd0);
            end
            if (e == 24) begin
                chk({tag, "_x_final"}, 32'(bus.x), 32'(exp_x));
                chk({tag, "_dac_final"}, 32'(bus.dac), 32'(exp_x));
                chk({tag, "_eoc_done"}, 32'(bus.eoc), 32'd0);
            end
            if ((e == rise - 1) && (rise > 25)) begin
                chk({tag, "_eoc_stall"}, 32'(bus.eoc), 32'd0);
                chk({tag, "_x_stall"}, 32'(bus.x), 32'(exp_x));
            end
            if (e == rise) begin
                chk({tag, "_eoc_rise"}, 32'(bus.eoc), 32'd1);
                chk({tag, "_x_idle"}, 32'(bus.x), 32'(exp_x));
            end
        end
    endtask

    initial begin
        logic [7:0] exp_g6;
        n_checks = 0;
        n_errors = 0;
        reset_   = 1'b0;
        bus.soc  = 1'b0;
        v_in     = 8'h00;
        glitch   = 1'b0;

        tick();
        tick();
        chk("rst_eoc", 32'(bus.eoc), 32'd1);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_dac", 32'(bus.dac), 32'd0);
        reset_ = 1'b1;
        tick();
        chk("idle_eoc", 32'(bus.eoc), 32'd1);

        do_conv("a7", 8'hA7, 8'hA7, 8'h00, 3, -1, 1'b1);
        do_conv("zero", 8'h00, 8'h00, 8'hA7, 3, -1, 1'b0);
        do_conv("full", 8'hFF, 8'hFF, 8'h00, 3, -1, 1'b0);
        do_conv("hold", 8'h61, 8'h61, 8'hFF, 40, -1, 1'b0);

        // A reset asserted mid-conversion discards the partial result
        v_in = 8'hA7;
        bus.soc = 1'b1;
        tick();
        bus.soc = 1'b0;
        repeat (9) tick();
        reset_ = 1'b0;
        tick();
        chk("midrst_eoc", 32'(bus.eoc), 32'd1);
        chk("midrst_x", 32'(bus.x), 32'd0);
        chk("midrst_dac", 32'(bus.dac), 32'd0);
        reset_ = 1'b1;
        tick();
        chk("midrst_idle", 32'(bus.eoc), 32'd1);
        do_conv("post_rst", 8'h5A, 8'h5A, 8'h00, 3, -1, 1'b0);

        // Back-to-back: the second soc is raised right after eoc rises
        do_conv("b2b_1", 8'h3C, 8'h3C, 8'h5A, 3, -1, 1'b0);
        do_conv("b2b_2", 8'hC3, 8'hC3, 8'h3C, 3, -1, 1'b0);

        // Bit-6 window for V=0xA7 covers edges k+4 (cnt=2), k+5 (cnt=1)
        // and k+6 (cnt=0, decision).
        do_conv("glitch_c1", 8'hA7, 8'hA7, 8'hC3, 3, 5, 1'b0);
`ifdef SAR_CMP_MAJORITY_EN
        exp_g6 = 8'hA7;
`else
        // Bit 6 is forced to 1, so dac becomes 0xC0. Every later trial code
        // is then above 0xA7, so all the lower bits clear.
        exp_g6 = 8'hC0;
`endif
        do_conv("glitch_c0", 8'hA7, exp_g6, 8'hA7, 3, 6, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
